// File: rtl/binary_encoder_drain_pkg.sv
// Shared request-line types for the binary decoder/encoder pair.
// The default request count sets the width of the vector and index types.
package binary_codec_pkg;

  localparam int N_REQ = 4;

  typedef logic [N_REQ-1:0]         req_vec_t;
  typedef logic [$clog2(N_REQ)-1:0] req_idx_t;

endpackage

// File: rtl/binary_encoder_drain_lsb_priority_encoder.sv
// Combinational lowest-set-bit encoder: index of the lowest set bit,
// whether any bit is set, and whether exactly one bit is set.
module lsb_priority_encoder #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any,
  output logic         only_one
);

  // Scanning from the top down leaves the lowest set bit as the final winner.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
  end

  assign any      = |vec;
  assign only_one = any && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/binary_encoder_drain.sv
// Drains a multi-hot request vector into a stream of binary indices,
// lowest index first, one per output handshake.
module binary_encoder_drain
  import binary_codec_pkg::*;
#(
  parameter int N = N_REQ,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last
);

  logic [N-1:0] pend;
  logic [N-1:0] clr_mask;
  logic [W-1:0] low_idx;
  logic         pend_any;
  logic         pend_one;
  logic         slot_free;
  logic         accept;

  lsb_priority_encoder #(
    .N (N),
    .W (W)
  ) u_enc (
    .vec      (pend),
    .idx      (low_idx),
    .any      (pend_any),
    .only_one (pend_one)
  );

  assign in_ready  = (pend == '0);
  assign accept    = in_valid && in_ready;
  assign slot_free = !out_valid || out_ready;

  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < N; i++) begin
      clr_mask[i] = (low_idx == W'(i));
    end
  end

  // Accept only happens with pend empty and load only with pend non-empty, so
  // the pend update never has to merge; the slot can still drain while a new
  // vector is accepted, which is the idle output cycle between vectors.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend      <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      if (accept) begin
        pend <= in_vec;
      end else if (slot_free && pend_any) begin
        pend <= pend & ~clr_mask;
      end

      if (slot_free) begin
        if (pend_any) begin
          out_valid <= 1'b1;
          out_idx   <= low_idx;
          out_last  <= pend_one;
        end else if (out_valid) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule
